end_ptr_gen: RTL and testbench

END_PTR_GEN -- requirements
Module: end_ptr_gen

---
 rtl/end_ptr_gen.sv | 121 ++++++++++++
 tb/tb_end_ptr_gen.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/end_ptr_gen.sv
// End-pointer generator: walks one filter window through a circular input-feature
// buffer starting at start_ptr, strobing reads and reporting the last address read.
module end_ptr_gen #(
  parameter int ADDR_WIDTH = 16,
  parameter int IF_LENGTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] filter_size,
  input  logic                  sp_valid,
  input  logic [ADDR_WIDTH-1:0] start_ptr,
  input  logic                  data_ready,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_ptr,
  output logic [ADDR_WIDTH-1:0] end_ptr,
  output logic                  next_start,
  output logic                  rst_p_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SP,
    TRAVERSE,
    DONE
  } state_t;

  // Buffer length widened by one bit so pointer+1 and oversize requests compare without overflow.
  localparam logic [ADDR_WIDTH:0] LEN_EXT = (ADDR_WIDTH+1)'(IF_LENGTH);

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_fs;
  logic [ADDR_WIDTH-1:0] r_count;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH-1:0] r_end_ptr;
  logic                  r_err;

  logic                  w_size_ok;
  logic                  w_last;
  logic                  w_rd_en;
  logic [ADDR_WIDTH:0]   w_ptr_inc;
  logic [ADDR_WIDTH-1:0] w_ptr_next;
  logic [ADDR_WIDTH-1:0] w_sp_load;

  assign w_size_ok  = (filter_size != '0) && ({1'b0, filter_size} <= LEN_EXT);
  assign w_last     = (r_count == r_fs - ADDR_WIDTH'(1));
  assign w_rd_en    = (r_state == TRAVERSE) && data_ready;
  assign w_ptr_inc  = {1'b0, r_rd_ptr} + (ADDR_WIDTH+1)'(1);
  assign w_ptr_next = (w_ptr_inc >= LEN_EXT) ? '0 : w_ptr_inc[ADDR_WIDTH-1:0];
  assign w_sp_load  = ({1'b0, start_ptr} >= LEN_EXT) ? '0 : start_ptr;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // NOTE: next state defaults to the current state first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:     if (start && w_size_ok) w_state_next = WAIT_SP;
      WAIT_SP:  if (sp_valid)           w_state_next = TRAVERSE;
      TRAVERSE: if (w_rd_en && w_last)  w_state_next = DONE;
      DONE:                             w_state_next = IDLE;
      default:                          w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fs      <= '0;
      r_count   <= '0;
      r_rd_ptr  <= '0;
      r_end_ptr <= '0;
      r_err     <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_fs  <= filter_size;
            r_err <= !w_size_ok;
          end
        end
        WAIT_SP: begin
          if (sp_valid) begin
            r_rd_ptr <= w_sp_load;
            r_count  <= '0;
          end
        end
        TRAVERSE: begin
          // The last read leaves rd_ptr on the final address; end_ptr captures it.
          if (w_rd_en) begin
            if (w_last) begin
              r_end_ptr <= r_rd_ptr;
            end else begin
              r_count  <= r_count + ADDR_WIDTH'(1);
              r_rd_ptr <= w_ptr_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_en       = w_rd_en;
  assign rd_ptr      = r_rd_ptr;
  assign end_ptr     = r_end_ptr;
  assign next_start  = (r_state == DONE);
  assign rst_p_valid = (r_state == DONE);
  assign done        = (r_state == DONE);
  assign busy        = (r_state != IDLE);
  assign err         = r_err;

endmodule

// File: tb/tb_end_ptr_gen.sv
// Scoreboard bench for end_ptr_gen: directed windows push expected reads, end
// pointers and pulse cycles; a negedge monitor pops and compares them.
module tb_end_ptr_gen;

  localparam int AW  = 16;
  localparam int LEN = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] filter_size = '0;
  logic          sp_valid = 1'b0;
  logic [AW-1:0] start_ptr = '0;
  logic          data_ready = 1'b0;
  logic          rd_en;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] end_ptr;
  logic          next_start;
  logic          rst_p_valid;
  logic          busy;
  logic          done;
  logic          err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int rd_q[$];
  int end_q[$];
  int done_q[$];
  int err_q[$];

  end_ptr_gen #(.ADDR_WIDTH(AW), .IF_LENGTH(LEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .filter_size (filter_size),
    .sp_valid    (sp_valid),
    .start_ptr   (start_ptr),
    .data_ready  (data_ready),
    .rd_en       (rd_en),
    .rd_ptr      (rd_ptr),
    .end_ptr     (end_ptr),
    .next_start  (next_start),
    .rst_p_valid (rst_p_valid),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic exp_rd(input int a);
    rd_q.push_back(a);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rd_en"},       32'(rd_en),       32'd0);
    check({tag, "_rd_ptr"},      32'(rd_ptr),      32'd0);
    check({tag, "_end_ptr"},     32'(end_ptr),     32'd0);
    check({tag, "_next_start"},  32'(next_start),  32'd0);
    check({tag, "_rst_p_valid"}, 32'(rst_p_valid), 32'd0);
    check({tag, "_busy"},        32'(busy),        32'd0);
    check({tag, "_done"},        32'(done),        32'd0);
    check({tag, "_err"},         32'(err),         32'd0);
  endtask

  // Drives a one-cycle start. exp_end < 0: no completion expected.
  // done_after / err_after are hand-computed cycles counted from the cycle start is raised.
  task automatic issue(input int fs, input int sp, input bit sp_now,
                       input int exp_end, input int done_after, input bit exp_err);
    int k;
    @(posedge clk); #1;
    k           = cyc;
    filter_size = AW'(fs);
    start_ptr   = AW'(sp);
    sp_valid    = sp_now;
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (exp_err) err_q.push_back(k + 1);
    if (exp_end >= 0) begin
      end_q.push_back(exp_end);
      done_q.push_back(k + done_after);
    end
  endtask

  // Monitor: every read strobe, completion pulse and error pulse must match the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_en) begin
        if (rd_q.size() == 0) check("unexpected_rd_en", 32'(rd_en), 32'd0);
        else                  check("rd_ptr", 32'(rd_ptr), rd_q.pop_front());
      end
      if (done) begin
        if (end_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          check("end_ptr",    32'(end_ptr), end_q.pop_front());
          check("done_cycle", cyc, done_q.pop_front());
          check("next_start_with_done",  32'(next_start),  32'd1);
          check("rst_p_valid_with_done", 32'(rst_p_valid), 32'd1);
          check("busy_in_done",          32'(busy),        32'd1);
        end
      end else if (next_start || rst_p_valid) begin
        check("pulse_without_done", 32'({next_start, rst_p_valid}), 32'd0);
      end
      if (err) begin
        if (err_q.size() == 0) begin
          check("unexpected_err", 32'(err), 32'd0);
        end else begin
          check("err_cycle",   cyc, err_q.pop_front());
          check("busy_on_err", 32'(busy), 32'd0);
        end
      end
    end
  end

  initial begin
    #1 rst = 1'b1;
    #2 check_idle("reset");
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    data_ready = 1'b1;

    // Basic window: reads 2,3,4, end 4, completion 5 cycles after start.
    exp_rd(2); exp_rd(3); exp_rd(4);
    issue(3, 2, 1'b1, 4, 5, 1'b0);
    repeat (6) @(posedge clk);

    // Wrap: reads 10,11,0,1, end 1.
    exp_rd(10); exp_rd(11); exp_rd(0); exp_rd(1);
    issue(4, 10, 1'b1, 1, 6, 1'b0);
    repeat (7) @(posedge clk);

    // Full-length window from 5, with a stray start and a new start_ptr mid-window.
    for (int a = 5; a < LEN; a++) exp_rd(a);
    for (int a = 0; a < 5; a++) exp_rd(a);
    issue(12, 5, 1'b1, 4, 14, 1'b0);
    @(posedge clk); #1;
    filter_size = AW'(0);
    start       = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    start_ptr = AW'(0);
    repeat (14) @(posedge clk);

    // Out-of-range start pointer maps to 0.
    exp_rd(0); exp_rd(1);
    issue(2, 14, 1'b1, 1, 4, 1'b0);
    repeat (5) @(posedge clk);

    // Single-entry window at the last address.
    exp_rd(11);
    issue(1, 11, 1'b1, 11, 3, 1'b0);
    repeat (4) @(posedge clk);

    // Illegal sizes: err pulse each, no reads, FSM stays idle.
    issue(0, 3, 1'b1, -1, 0, 1'b1);
    repeat (3) @(posedge clk);
    issue(13, 3, 1'b1, -1, 0, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk) check("busy_after_illegal", 32'(busy), 32'd0);

    // Stall: data_ready low for the first three TRAVERSE cycles.
    data_ready = 1'b0;
    exp_rd(5); exp_rd(6);
    issue(2, 5, 1'b1, 6, 7, 1'b0);
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      check("stall_rd_en",  32'(rd_en),  32'd0);
      check("stall_rd_ptr", 32'(rd_ptr), 32'd5);
      @(posedge clk);
    end
    #1 data_ready = 1'b1;
    repeat (5) @(posedge clk);

    // sp_valid low for five cycles: FSM waits busy with no reads.
    exp_rd(7); exp_rd(8);
    issue(2, 7, 1'b0, 8, 9, 1'b0);
    repeat (5) begin
      @(negedge clk);
      check("wait_sp_busy",  32'(busy),  32'd1);
      check("wait_sp_rd_en", 32'(rd_en), 32'd0);
    end
    @(posedge clk); #1;
    sp_valid = 1'b1;
    repeat (6) @(posedge clk);

    // Reset at count=1 mid-window: outputs drop at once, no completion.
    exp_rd(0);
    issue(4, 0, 1'b1, -1, 0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_idle("async_reset");
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk) check_idle("post_reset");

    exp_rd(0);
    issue(1, 0, 1'b1, 0, 3, 1'b0);
    repeat (5) @(posedge clk);

    @(negedge clk);
    check("rd_q_drained",   32'(rd_q.size()),   32'd0);
    check("end_q_drained",  32'(end_q.size()),  32'd0);
    check("done_q_drained", 32'(done_q.size()), 32'd0);
    check("err_q_drained",  32'(err_q.size()),  32'd0);
    check("final_busy",     32'(busy),          32'd0);
    check("final_end_ptr",  32'(end_ptr),       32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
